alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance between two requesters, such as the main datapath and a coprocessor/debug port.
- Arbitrates round-robin with a valid/ready request handshake per side.
- Registers the operands into the ALU, captures the result and Zero flag, and returns them on a per-requester valid/ready response channel.
- Sits between the requesters and the ALU; the ALU itself is unchanged.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- CNT_W, 16, width of the grant counters (optional feature only).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ0_VALID  in  1  requester 0 has an operation pending.
- REQ0_READY  out  1  requester 0 operation accepted this cycle.
- REQ0_OP_A  in  WIDTH  requester 0 operand A.
- REQ0_OP_B  in  WIDTH  requester 0 operand B.
- REQ0_CTRL  in  3  requester 0 ALU control code.
- RSP0_VALID  out  1  result available for requester 0.
- RSP0_READY  in  1  requester 0 consumes the result.
- RSP0_RESULT  out  WIDTH  result for requester 0.
- RSP0_ZERO  out  1  Zero flag for requester 0.
- REQ1_* / RSP1_*: same set as requester 0, for requester 1.
- ALU_OP_A  out  WIDTH  registered operand A to the ALU.
- ALU_OP_B  out  WIDTH  registered operand B to the ALU.
- ALU_CTRL  out  3  registered control code to the ALU.
- ALU_RESULT  in  WIDTH  ALU result, combinational.
- ALU_ZERO  in  1  ALU Zero flag.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Registers: prio pointer (reset 0), owner (reset 0).
- Reset values of outputs: all of ALU_OP_A/ALU_OP_B/ALU_CTRL, REQn_READY, RSPn_VALID, RSPn_RESULT and RSPn_ZERO are 0.
- IDLE:
  - If only one REQn_VALID is high, grant that requester.
  - If both are high, grant the requester named by prio.
  - On grant: REQn_READY is high combinationally in that same cycle for the granted side only. Latch REQn_OP_A/OP_B/CTRL into the ALU_* registers, set owner = n, and go to EXEC.
  - With no valid, stay in IDLE.
- EXEC (one cycle): the ALU sees registered operands. Capture ALU_RESULT/ALU_ZERO into the owner's RSP registers. Set RSP_VALID[owner] and go to RESP.
- RESP:
  - RSPn_VALID stays high and RSPn_RESULT/RSPn_ZERO stay stable until RSPn_READY.
  - On the handshake: clear RSP_VALID, set prio = ~owner, return to IDLE.
  - No new request is accepted while in RESP.
- Latency: request accepted at cycle T gives RSP_VALID at T+2. Minimum spacing between accepts is 3 cycles.
- ALU_* registers hold their last values outside the grant cycle. No spurious change.
- REQn_READY is never high in EXEC or RESP. At most one REQn_READY is high per cycle.
- Protocol rule: a requester holds VALID and its operands stable until READY. The arbiter does not check this.
- Fairness:
  - With both requesters continuously valid, grants alternate 0,1,0,1…
  - A lone requester is served back-to-back regardless of prio.
- Reset mid-operation (EXEC or RESP): the in-flight result is discarded. RSP_VALID drops immediately, the FSM goes to IDLE and prio returns to 0.
- Width: the arbiter only passes the result through, so WIDTH bits everywhere. Signedness is the ALU's concern.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- With the macro defined, two extra output ports exist: GNT_CNT0 and GNT_CNT1, each CNT_W bits.
  - Each counter increments by 1 on every grant handshake (REQn_VALID and REQn_READY) of its requester.
  - Counters wrap modulo 2^CNT_W and reset to 0 on RST.
- Without the macro: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset then idle: RST pulse with no valids -> all outputs 0, no READY, no RSP_VALID for 10 cycles.
- Single op: REQ0 A=5, B=3, CTRL=010 accepted at T -> ALU_OP_A=5 at T+1, RSP0_VALID=1 with RESULT=8 and ZERO=0 at T+2. With RSP0_READY tied high, RSP0_VALID clears at T+3.
- Contention: both valid from reset, REQ0 A=7,B=7,CTRL=011 and REQ1 A=0xF0,B=0x0F,CTRL=001 -> REQ0 granted first (RESULT 0, ZERO 1), then REQ1 (RESULT 0xFF). Grant order continues 0,1,0,1 over 8 ops.
- Backpressure: hold RSP1_READY low 5 cycles in RESP -> RSP1_VALID/RESULT stable, REQ0_READY stays 0 despite REQ0_VALID. The grant happens the cycle after the RSP1 handshake.
- Reset in RESP: assert RST while RSP0_VALID=1 -> RSP0_VALID drops asynchronously, and the next contention grants requester 0.
- Stats (ALU_ARB_STATS_EN, CNT_W=4): 17 REQ1 ops -> GNT_CNT1=1 (wrapped), GNT_CNT0=0.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Bundles the two requester channels and the ALU-facing bus of alu_share_arbiter.
// Ports: REQn_* request handshake + operands, RSPn_* response handshake + result,
//        ALU_* registered operands out / combinational result in. slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             REQ0_VALID;
  logic             REQ0_READY;
  logic [WIDTH-1:0] REQ0_OP_A;
  logic [WIDTH-1:0] REQ0_OP_B;
  logic [2:0]       REQ0_CTRL;
  logic             RSP0_VALID;
  logic             RSP0_READY;
  logic [WIDTH-1:0] RSP0_RESULT;
  logic             RSP0_ZERO;

  logic             REQ1_VALID;
  logic             REQ1_READY;
  logic [WIDTH-1:0] REQ1_OP_A;
  logic [WIDTH-1:0] REQ1_OP_B;
  logic [2:0]       REQ1_CTRL;
  logic             RSP1_VALID;
  logic             RSP1_READY;
  logic [WIDTH-1:0] RSP1_RESULT;
  logic             RSP1_ZERO;

  logic [WIDTH-1:0] ALU_OP_A;
  logic [WIDTH-1:0] ALU_OP_B;
  logic [2:0]       ALU_CTRL;
  logic [WIDTH-1:0] ALU_RESULT;
  logic             ALU_ZERO;

  modport slave (
    input  REQ0_VALID, REQ0_OP_A, REQ0_OP_B, REQ0_CTRL, RSP0_READY,
    output REQ0_READY, RSP0_VALID, RSP0_RESULT, RSP0_ZERO,
    input  REQ1_VALID, REQ1_OP_A, REQ1_OP_B, REQ1_CTRL, RSP1_READY,
    output REQ1_READY, RSP1_VALID, RSP1_RESULT, RSP1_ZERO,
    output ALU_OP_A, ALU_OP_B, ALU_CTRL,
    input  ALU_RESULT, ALU_ZERO
  );

  modport master (
    output REQ0_VALID, REQ0_OP_A, REQ0_OP_B, REQ0_CTRL, RSP0_READY,
    input  REQ0_READY, RSP0_VALID, RSP0_RESULT, RSP0_ZERO,
    output REQ1_VALID, REQ1_OP_A, REQ1_OP_B, REQ1_CTRL, RSP1_READY,
    input  REQ1_READY, RSP1_VALID, RSP1_RESULT, RSP1_ZERO,
    input  ALU_OP_A, ALU_OP_B, ALU_CTRL,
    output ALU_RESULT, ALU_ZERO
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two valid/ready requesters.
// Latency: accept at T -> RSPn_VALID at T+2; accepts are at least 3 cycles apart.
// Backpressure: RSPn_VALID holds until RSPn_READY; no request accepted while a result waits.
// Ports: CLK, RST (async, active-high), bus (alu_share_arbiter_if.slave).
// Optional: define ALU_ARB_STATS_EN to add CNT_W-bit grant counters GNT_CNT0/GNT_CNT1.
module alu_share_arbiter #(
  parameter int WIDTH = 32
`ifdef ALU_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic CLK,
  input  logic RST,
  alu_share_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  , output logic [CNT_W-1:0] GNT_CNT0
  , output logic [CNT_W-1:0] GNT_CNT1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [1:0]       rsp_vld_q, rsp_vld_d;
  logic             gnt0, gnt1;
  logic             rsp_hs;

  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [2:0]       alu_ctrl_q;
  logic [WIDTH-1:0] rsp0_res_q, rsp1_res_q;
  logic             rsp0_zero_q, rsp1_zero_q;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    rsp_vld_d = rsp_vld_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rsp_hs    = 1'b0;
    case (state_q)
      IDLE: begin
        // prio only matters when both ask; a lone requester always wins.
        if (bus.REQ0_VALID && (!bus.REQ1_VALID || !prio_q)) begin
          gnt0 = 1'b1;
        end else if (bus.REQ1_VALID) begin
          gnt1 = 1'b1;
        end
        if (gnt0 || gnt1) begin
          owner_d = gnt1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_vld_d[owner_q] = 1'b1;
        state_d            = RESP;
      end
      RESP: begin
        rsp_hs = owner_q ? bus.RSP1_READY : bus.RSP0_READY;
        if (rsp_hs) begin
          rsp_vld_d = 2'b00;
          prio_d    = ~owner_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      rsp_vld_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  // Operand registers only move on a grant, so the ALU inputs never glitch otherwise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      rsp0_res_q  <= '0;
      rsp1_res_q  <= '0;
      rsp0_zero_q <= 1'b0;
      rsp1_zero_q <= 1'b0;
    end else begin
      if (gnt0) begin
        alu_a_q    <= bus.REQ0_OP_A;
        alu_b_q    <= bus.REQ0_OP_B;
        alu_ctrl_q <= bus.REQ0_CTRL;
      end else if (gnt1) begin
        alu_a_q    <= bus.REQ1_OP_A;
        alu_b_q    <= bus.REQ1_OP_B;
        alu_ctrl_q <= bus.REQ1_CTRL;
      end
      if (state_q == EXEC) begin
        if (owner_q) begin
          rsp1_res_q  <= bus.ALU_RESULT;
          rsp1_zero_q <= bus.ALU_ZERO;
        end else begin
          rsp0_res_q  <= bus.ALU_RESULT;
          rsp0_zero_q <= bus.ALU_ZERO;
        end
      end
    end
  end

  assign bus.REQ0_READY  = gnt0;
  assign bus.REQ1_READY  = gnt1;
  assign bus.RSP0_VALID  = rsp_vld_q[0];
  assign bus.RSP1_VALID  = rsp_vld_q[1];
  assign bus.RSP0_RESULT = rsp0_res_q;
  assign bus.RSP1_RESULT = rsp1_res_q;
  assign bus.RSP0_ZERO   = rsp0_zero_q;
  assign bus.RSP1_ZERO   = rsp1_zero_q;
  assign bus.ALU_OP_A    = alu_a_q;
  assign bus.ALU_OP_B    = alu_b_q;
  assign bus.ALU_CTRL    = alu_ctrl_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  // Grants imply VALID, so gntN is exactly the request handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0) cnt0_q <= cnt0_q + CNT_W'(1);
      if (gnt1) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign GNT_CNT0 = cnt0_q;
  assign GNT_CNT1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, hand-built corner sequences,
// and randomized traffic against a transaction-level timing/result model.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  alu_share_arbiter_if #(.WIDTH(W)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [3:0] gnt_cnt0, gnt_cnt1;
  alu_share_arbiter #(.WIDTH(W), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .GNT_CNT0(gnt_cnt0), .GNT_CNT1(gnt_cnt1)
  );
`else
  alu_share_arbiter #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );
`endif

  // Reference ALU: 000 and, 001 or, 010 add, 011 xor, 110 sub, 111 signed slt.
  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] c);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return a ^ b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  assign bus.ALU_RESULT = alu_f(bus.ALU_OP_A, bus.ALU_OP_B, bus.ALU_CTRL);
  assign bus.ALU_ZERO   = (alu_f(bus.ALU_OP_A, bus.ALU_OP_B, bus.ALU_CTRL) == '0);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int s, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] c);
    if (s == 0) begin
      bus.REQ0_VALID = v; bus.REQ0_OP_A = a; bus.REQ0_OP_B = b; bus.REQ0_CTRL = c;
    end else begin
      bus.REQ1_VALID = v; bus.REQ1_OP_A = a; bus.REQ1_OP_B = b; bus.REQ1_CTRL = c;
    end
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? bus.REQ0_READY : bus.REQ1_READY;
  endfunction
  function automatic logic rvld(input int s);
    return (s == 0) ? bus.RSP0_VALID : bus.RSP1_VALID;
  endfunction
  function automatic logic [W-1:0] rres(input int s);
    return (s == 0) ? bus.RSP0_RESULT : bus.RSP1_RESULT;
  endfunction
  function automatic logic rzero(input int s);
    return (s == 0) ? bus.RSP0_ZERO : bus.RSP1_ZERO;
  endfunction

  // Called at a falling edge; returns at a falling edge.
  task automatic do_reset();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.RSP0_READY = 1'b1;
    bus.RSP1_READY = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Presents one request from a falling edge; returns at the falling edge of T+1 with VALID dropped.
  task automatic issue(input int s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] c, output int waited);
    bit ok = 0;
    waited = 0;
    set_req(s, 1'b1, a, b, c);
    for (int k = 0; k < 20; k++) begin
      #1;
      if (rdy(s)) begin
        ok = 1;
        break;
      end
      waited++;
      @(negedge CLK);
    end
    if (!ok) chk($sformatf("accept timeout side%0d", s), 0, 1);
    @(negedge CLK);
    set_req(s, 1'b0, '0, '0, '0);
  endtask

  typedef struct {
    int         side;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0] c;
    logic [W-1:0] res;
    logic       z;
  } vec_t;

  initial begin
    vec_t vt[8];
    int   waited;
    int   gorder[8];
    int   g;
    logic [W-1:0] held;

    RST = 1'b1;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    bus.RSP0_READY = 1'b0;
    bus.RSP1_READY = 1'b0;

    // ---- reset state and 10 idle cycles ----
    #1;
    chk("reset ALU_OP_A", bus.ALU_OP_A, 0);
    chk("reset ALU_OP_B", bus.ALU_OP_B, 0);
    chk("reset ALU_CTRL", bus.ALU_CTRL, 0);
    chk("reset RSP results", {bus.RSP0_RESULT, bus.RSP1_RESULT}, 0);
    chk("reset RSP zeros", {bus.RSP0_ZERO, bus.RSP1_ZERO}, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle ready/rsp_valid",
          {bus.REQ0_READY, bus.REQ1_READY, bus.RSP0_VALID, bus.RSP1_VALID}, 0);
      @(negedge CLK);
    end

    // ---- directed single operations, issued back-to-back at minimum spacing ----
    vt[0] = '{0, 32'd5,         32'd3,         3'b010, 32'd8,         1'b0};
    vt[1] = '{0, 32'd7,         32'd7,         3'b011, 32'd0,         1'b1};
    vt[2] = '{1, 32'h0000_00F0, 32'h0000_000F, 3'b001, 32'h0000_00FF, 1'b0};
    vt[3] = '{1, 32'd3,         32'd5,         3'b110, 32'hFFFF_FFFE, 1'b0};
    vt[4] = '{0, 32'hFFFF_FFFF, 32'd1,         3'b010, 32'd0,         1'b1};
    vt[5] = '{1, 32'hFFFF_FFFE, 32'd1,         3'b111, 32'd1,         1'b0};
    vt[6] = '{0, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 3'b000, 32'h0505_0505, 1'b0};
    vt[7] = '{1, 32'h8000_0000, 32'd0,         3'b110, 32'h8000_0000, 1'b0};
    bus.RSP0_READY = 1'b1;
    bus.RSP1_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(vt[i].side, vt[i].a, vt[i].b, vt[i].c, waited);
      chk($sformatf("vec%0d accept delay", i), waited, 0);
      #1;
      chk($sformatf("vec%0d ALU_OP_A", i), bus.ALU_OP_A, vt[i].a);
      chk($sformatf("vec%0d ALU_OP_B", i), bus.ALU_OP_B, vt[i].b);
      chk($sformatf("vec%0d ALU_CTRL", i), bus.ALU_CTRL, vt[i].c);
      chk($sformatf("vec%0d T+1 rsp_valid", i), {bus.RSP1_VALID, bus.RSP0_VALID}, 0);
      @(negedge CLK);
      #1;
      chk($sformatf("vec%0d T+2 rsp_valid", i), {bus.RSP1_VALID, bus.RSP0_VALID},
          (vt[i].side == 0) ? 2'b01 : 2'b10);
      chk($sformatf("vec%0d result", i), rres(vt[i].side), vt[i].res);
      chk($sformatf("vec%0d zero", i), rzero(vt[i].side), vt[i].z);
      @(negedge CLK);
      #1;
      chk($sformatf("vec%0d T+3 rsp_valid", i), rvld(vt[i].side), 0);
    end
    @(negedge CLK);

    // ---- contention from reset: grants alternate 0,1,0,1... ----
    RST = 1'b1;
    set_req(0, 1'b1, 32'd7, 32'd7, 3'b011);
    set_req(1, 1'b1, 32'h0000_00F0, 32'h0000_000F, 3'b001);
    bus.RSP0_READY = 1'b1;
    bus.RSP1_READY = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    g = 0;
    for (int cyc = 0; cyc < 60 && g < 8; cyc++) begin
      #1;
      chk("contention one ready", bus.REQ0_READY & bus.REQ1_READY, 0);
      if (bus.RSP0_VALID) chk("contention rsp0", {bus.RSP0_ZERO, bus.RSP0_RESULT}, {1'b1, 32'd0});
      if (bus.RSP1_VALID) chk("contention rsp1", {bus.RSP1_ZERO, bus.RSP1_RESULT}, {1'b0, 32'hFF});
      if (bus.REQ0_READY || bus.REQ1_READY) begin
        gorder[g] = bus.REQ1_READY ? 1 : 0;
        g++;
      end
      @(negedge CLK);
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    chk("contention grant count", g, 8);
    for (int i = 0; i < g; i++) chk($sformatf("contention grant%0d", i), gorder[i], i % 2);
    drain(4);

    // ---- backpressure on RSP1 ----
    bus.RSP1_READY = 1'b0;
    issue(1, 32'h12, 32'h34, 3'b010, waited);
    @(negedge CLK);
    set_req(0, 1'b1, 32'd9, 32'd1, 3'b010);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp RSP1_VALID held", bus.RSP1_VALID, 1);
      chk("bp RSP1_RESULT held", bus.RSP1_RESULT, 32'h46);
      chk("bp REQ0_READY low", bus.REQ0_READY, 0);
      @(negedge CLK);
    end
    bus.RSP1_READY = 1'b1;
    #1;
    chk("bp REQ0_READY in handshake cycle", bus.REQ0_READY, 0);
    @(negedge CLK);
    bus.RSP1_READY = 1'b0;
    #1;
    chk("bp REQ0 granted after handshake", bus.REQ0_READY, 1);
    chk("bp RSP1_VALID cleared", bus.RSP1_VALID, 0);
    @(negedge CLK);
    set_req(0, 1'b0, '0, '0, '0);
    @(negedge CLK);
    #1;
    chk("bp rsp0 after release", {bus.RSP0_VALID, bus.RSP0_RESULT}, {1'b1, 32'd10});
    @(negedge CLK);
    drain(3);

    // ---- reset while a result waits in RESP ----
    issue(0, 32'd2, 32'd2, 3'b010, waited);   // completes, leaves prio pointing at 1
    drain(3);
    bus.RSP0_READY = 1'b0;
    issue(0, 32'd1, 32'd1, 3'b010, waited);
    @(negedge CLK);
    #1;
    chk("rstresp RSP0_VALID before", bus.RSP0_VALID, 1);
    #1;
    RST = 1'b1;
    #1;
    chk("rstresp RSP0_VALID async drop", bus.RSP0_VALID, 0);
    set_req(0, 1'b1, 32'd4, 32'd4, 3'b011);
    set_req(1, 1'b1, 32'd4, 32'd5, 3'b010);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rstresp contention grant", {bus.REQ1_READY, bus.REQ0_READY}, 2'b01);
    @(negedge CLK);
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    drain(4);

    // ---- randomized traffic vs transaction-level model ----
    begin
      bit           vld[2];
      logic [W-1:0] ca[2], cb[2];
      logic [2:0]   cc[2];
      logic         rr[2];
      bit           busy = 0;
      int           owner = 0, acc_cyc = 0, free_cyc = 0, mprio = 0;
      logic [W-1:0] exp_res = '0, exp_a = '0, exp_b = '0;
      logic         exp_z = 1'b0;
      logic [1:0]   exp_r, exp_v;
      vld[0] = 0; vld[1] = 0;
      do_reset();
      for (int cyc = 0; cyc < 2000; cyc++) begin
        for (int s = 0; s < 2; s++) begin
          if (!vld[s] && $urandom_range(0, 2) == 0) begin
            vld[s] = 1;
            ca[s]  = $urandom;
            cb[s]  = ($urandom_range(0, 3) == 0) ? ca[s] : W'($urandom);
            cc[s]  = 3'($urandom_range(0, 7));
          end
          set_req(s, vld[s], vld[s] ? ca[s] : '0, vld[s] ? cb[s] : '0, vld[s] ? cc[s] : '0);
          rr[s] = ($urandom_range(0, 3) != 0);
        end
        bus.RSP0_READY = rr[0];
        bus.RSP1_READY = rr[1];
        #1;
        exp_r = 2'b00;
        if (!busy && cyc >= free_cyc) begin
          if (vld[0] && vld[1]) exp_r = (mprio == 1) ? 2'b10 : 2'b01;
          else if (vld[0])      exp_r = 2'b01;
          else if (vld[1])      exp_r = 2'b10;
        end
        chk("rand grant", {bus.REQ1_READY, bus.REQ0_READY}, exp_r);
        exp_v = (busy && cyc >= acc_cyc + 2) ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        chk("rand rsp_valid", {bus.RSP1_VALID, bus.RSP0_VALID}, exp_v);
        if (busy && cyc == acc_cyc + 1)
          chk("rand alu operands", {bus.ALU_OP_A, bus.ALU_OP_B}, {exp_a, exp_b});
        if (exp_v != 2'b00) begin
          chk("rand result", rres(owner), exp_res);
          chk("rand zero", rzero(owner), exp_z);
          if (rr[owner]) begin
            busy     = 0;
            free_cyc = cyc + 1;
            mprio    = 1 - owner;
          end
        end
        if (exp_r != 2'b00) begin
          owner   = (exp_r == 2'b10) ? 1 : 0;
          busy    = 1;
          acc_cyc = cyc;
          exp_a   = ca[owner];
          exp_b   = cb[owner];
          exp_res = alu_f(ca[owner], cb[owner], cc[owner]);
          exp_z   = (exp_res == '0);
          vld[owner] = 0;
        end
        @(negedge CLK);
      end
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      drain(4);
    end

`ifdef ALU_ARB_STATS_EN
    // ---- grant counters wrap at 2^CNT_W ----
    do_reset();
    chk("stats cnt after reset", {gnt_cnt1, gnt_cnt0}, 0);
    bus.RSP0_READY = 1'b1;
    bus.RSP1_READY = 1'b1;
    for (int i = 0; i < 17; i++) begin
      issue(1, W'(i), 32'd1, 3'b010, waited);
      @(negedge CLK);
      @(negedge CLK);
    end
    #1;
    chk("stats GNT_CNT1 wrapped", gnt_cnt1, 4'd1);
    chk("stats GNT_CNT0", gnt_cnt0, 4'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
